add_sub_n_seq: RTL and testbench

//  Parametrised multi-cycle adder/subtractor; next generation of the 16-bit ripple adder.

---
 rtl/add_sub_n_seq.sv | 83 ++++++++
 tb/tb_add_sub_n_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_n_seq.sv
// add_sub_n_seq: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, LSB slice first
// Ports: clk/reset (sync, active-high); in_valid/in_ready accept a, b, sub, cin;
// out_valid/out_ready hand over out, cout, ovf, zr, ng (held while out_valid && !out_ready).
module add_sub_n_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zr,
  output logic             ng
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, out_q, out_d;
  logic [IW-1:0] idx_q;
  logic carry_q, cout_q, ovf_q, zr_q, ng_q, last;
  logic [CHUNK:0] sum;
  assign last = idx_q == IW'(NSLICE - 1);
  // one CHUNK-bit ripple per cycle; the carry between slices lives in carry_q
  assign sum = {1'b0, a_q[int'(idx_q) * CHUNK +: CHUNK]} + {1'b0, b_q[int'(idx_q) * CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};
  always_comb begin
    out_d = out_q;
    out_d[int'(idx_q) * CHUNK +: CHUNK] = sum[CHUNK-1:0];
    state_d = (state_q == IDLE && in_valid) ? RUN :
              (state_q == RUN && last) ? DONE :
              (state_q == DONE && out_ready) ? IDLE : state_q;
  end
  assign in_ready = state_q == IDLE && !reset;
  assign out_valid = state_q == DONE;
  assign out = out_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
  assign zr = zr_q;
  assign ng = ng_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      out_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zr_q <= 1'b0;
      ng_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q <= a;
        b_q <= b ^ {WIDTH{sub}};
        carry_q <= sub | cin;
        idx_q <= '0;
      end
      if (state_q == RUN) begin
        out_q <= out_d;
        carry_q <= sum[CHUNK];
        idx_q <= idx_q + IW'(1);
        // flags come from the full result including the slice written this cycle
        if (last) begin
          cout_q <= sum[CHUNK];
          ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (out_d[WIDTH-1] != a_q[WIDTH-1]);
          zr_q <= out_d == '0;
          ng_q <= out_d[WIDTH-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_add_sub_n_seq.sv
// tb_add_sub_n_seq: directed and randomized checks of add_sub_n_seq in three geometries
module tb_add_sub_n_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int vec = 0;
  int err = 0;

  logic iv0 = 0, ir0, s0 = 0, c0 = 0, ov0, or0 = 0, co0, vf0, z0, n0;
  logic [15:0] a0 = 0, b0 = 0, o0;
  logic iv1 = 0, ir1, s1 = 0, c1 = 0, ov1, or1 = 0, co1, vf1, z1, n1;
  logic [31:0] a1 = 0, b1 = 0, o1;
  logic iv2 = 0, ir2, s2 = 0, c2 = 0, ov2, or2 = 0, co2, vf2, z2, n2;
  logic [15:0] a2 = 0, b2 = 0, o2;

  add_sub_n_seq #(.WIDTH(16), .CHUNK(4)) u0 (.clk(clk), .reset(rst), .in_valid(iv0), .in_ready(ir0),
    .a(a0), .b(b0), .sub(s0), .cin(c0), .out_valid(ov0), .out_ready(or0), .out(o0), .cout(co0),
    .ovf(vf0), .zr(z0), .ng(n0));
  add_sub_n_seq #(.WIDTH(32), .CHUNK(8)) u1 (.clk(clk), .reset(rst), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .sub(s1), .cin(c1), .out_valid(ov1), .out_ready(or1), .out(o1), .cout(co1),
    .ovf(vf1), .zr(z1), .ng(n1));
  add_sub_n_seq #(.WIDTH(16), .CHUNK(16)) u2 (.clk(clk), .reset(rst), .in_valid(iv2), .in_ready(ir2),
    .a(a2), .b(b2), .sub(s2), .cin(c2), .out_valid(ov2), .out_ready(or2), .out(o2), .cout(co2),
    .ovf(vf2), .zr(z2), .ng(n2));

  // Reference: exact integer arithmetic. Returns {ovf, cout, result[63:0]}.
  function automatic logic [65:0] model(int w, logic [63:0] ra, logic [63:0] rb, logic s, logic c);
    longint unsigned m, ua, ub, r;
    longint sa, sb, ex, hi, lo;
    logic co, ov;
    m = (64'd1 << w) - 64'd1;
    ua = ra & m;
    ub = rb & m;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    ex = s ? sa - sb : sa + sb + longint'(c);
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    ov = ex > hi || ex < lo;
    co = s ? (ua >= ub) : (ua + ub + 64'(c) > m);
    r = (s ? ua - ub : ua + ub + 64'(c)) & m;
    return {ov, co, r};
  endfunction

  function automatic logic [63:0] pick(int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // Launch one op on the W16/C4 instance; lat = edges from accept to out_valid.
  task automatic op0(input logic [15:0] ta, input logic [15:0] tb, input logic ts, input logic tc, output int lat);
    int n;
    n = 0;
    while (!ir0 && n < 20) begin @(posedge clk); #1; n++; end
    vec++;
    if (ir0 !== 1'b1) begin err++; $display("FAIL op0_ready got in_ready=%b want 1", ir0); end
    a0 = ta; b0 = tb; s0 = ts; c0 = tc; iv0 = 1;
    @(posedge clk); #1;
    iv0 = 0; a0 = 16'($urandom); b0 = 16'($urandom); s0 = 1'($urandom); c0 = 1'($urandom);
    lat = 0;
    while (!ov0 && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (ir0 !== 1'b0) begin err++; $display("FAIL rst_in_ready got %b want 0", ir0); end
    vec++;
    if ({ov0, o0, co0, vf0, z0, n0} !== 21'd0) begin err++; $display("FAIL rst_outputs got %h want 0", {ov0, o0, co0, vf0, z0, n0}); end
    rst = 0;
    #1;
    vec++;
    if ({ir0, ir1, ir2} !== 3'b111) begin err++; $display("FAIL rst_release_ready got %b want 111", {ir0, ir1, ir2}); end
  endtask

  task automatic test_directed;
    logic [15:0] ta[7] = '{16'h7FFF, 16'h0005, 16'h0005, 16'h0003, 16'hFFFF, 16'h8000, 16'h00F0};
    logic [15:0] tb[7] = '{16'h0001, 16'h0005, 16'h0005, 16'h0005, 16'h0000, 16'h0001, 16'h0010};
    logic        ts[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        tc[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] eo[7] = '{16'h8000, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000, 16'h7FFF, 16'h0100};
    logic        ec[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        ev[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    or0 = 1;
    for (int i = 0; i < 7; i++) begin
      op0(ta[i], tb[i], ts[i], tc[i], lat);
      vec++;
      if (lat != 4) begin err++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
      vec++;
      if (o0 !== eo[i]) begin err++; $display("FAIL dir%0d_out got %h want %h", i, o0, eo[i]); end
      vec++;
      if (co0 !== ec[i]) begin err++; $display("FAIL dir%0d_cout got %b want %b", i, co0, ec[i]); end
      vec++;
      if (vf0 !== ev[i]) begin err++; $display("FAIL dir%0d_ovf got %b want %b", i, vf0, ev[i]); end
      vec++;
      if ({z0, n0} !== {eo[i] == 16'h0, eo[i][15]}) begin err++; $display("FAIL dir%0d_zr_ng got %b%b want %b%b", i, z0, n0, eo[i] == 16'h0, eo[i][15]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    or0 = 0;
    op0(16'h1234, 16'h0F0F, 1'b0, 1'b1, lat);
    vec++;
    if (lat != 4 || o0 !== 16'h2144) begin err++; $display("FAIL bp_result got lat=%0d out=%h want lat=4 out=2144", lat, o0); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vec++;
      if ({ov0, ir0, o0, co0, vf0, z0, n0} !== {2'b10, 16'h2144, 4'b0000}) begin
        err++; $display("FAIL bp_hold%0d got v=%b r=%b out=%h flags=%b want v=1 r=0 out=2144 flags=0000", i, ov0, ir0, o0, {co0, vf0, z0, n0});
      end
    end
    or0 = 1;
    @(posedge clk); #1;
    vec++;
    if ({ov0, ir0} !== 2'b01) begin err++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", ov0, ir0); end
    vec++;
    if (o0 !== 16'h2144) begin err++; $display("FAIL bp_keep_out got %h want 2144", o0); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    or0 = 1;
    a0 = 16'h1111; b0 = 16'h2222; s0 = 0; c0 = 0; iv0 = 1;
    @(posedge clk); #1;
    iv0 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    vec++;
    if ({ov0, ir0, o0} !== {2'b01, 16'h0}) begin err++; $display("FAIL mid_rst got v=%b r=%b out=%h want v=0 r=1 out=0000", ov0, ir0, o0); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vec++;
      if (ov0 !== 1'b0) begin err++; $display("FAIL mid_rst_abandon%0d got out_valid=%b want 0", i, ov0); end
    end
    op0(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    vec++;
    if (lat != 4 || o0 !== 16'h5555 || co0 !== 1'b0) begin err++; $display("FAIL mid_rst_next got lat=%0d out=%h cout=%b want 4 5555 0", lat, o0, co0); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_w32_c8;
    logic [63:0] ra, rb;
    logic [65:0] m;
    logic rs, rc;
    int n, k;
    for (int i = 0; i < 1000; i++) begin
      ra = pick(32); rb = pick(32); rs = 1'($urandom); rc = 1'($urandom);
      m = model(32, ra, rb, rs, rc);
      n = 0;
      while (!ir1 && n < 20) begin @(posedge clk); #1; n++; end
      vec++;
      if (ir1 !== 1'b1) begin err++; $display("FAIL r32_ready%0d got %b want 1", i, ir1); end
      a1 = ra[31:0]; b1 = rb[31:0]; s1 = rs; c1 = rc; iv1 = 1; or1 = 0;
      @(posedge clk); #1;
      iv1 = 0; a1 = $urandom; b1 = $urandom; s1 = 1'($urandom); c1 = 1'($urandom);
      n = 0;
      while (!ov1 && n < 20) begin @(posedge clk); #1; n++; end
      vec++;
      if (n != 4) begin err++; $display("FAIL r32_latency%0d got %0d want 4", i, n); end
      vec++;
      if ({o1, co1, vf1, z1, n1} !== {m[31:0], m[64], m[65], m[31:0] == 32'h0, m[31]}) begin
        err++; $display("FAIL r32_result%0d a=%h b=%h sub=%b cin=%b got out=%h c=%b v=%b z=%b n=%b want out=%h c=%b v=%b", i, ra[31:0], rb[31:0], rs, rc, o1, co1, vf1, z1, n1, m[31:0], m[64], m[65]);
      end
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        @(posedge clk); #1;
        vec++;
        if ({ov1, ir1, o1} !== {2'b10, m[31:0]}) begin err++; $display("FAIL r32_hold%0d got v=%b r=%b out=%h want v=1 r=0 out=%h", i, ov1, ir1, o1, m[31:0]); end
      end
      or1 = 1;
      @(posedge clk); #1;
      or1 = 1'($urandom);
      vec++;
      if ({ov1, ir1} !== 2'b01) begin err++; $display("FAIL r32_take%0d got v=%b r=%b want v=0 r=1", i, ov1, ir1); end
    end
  endtask

  task automatic test_random_w16_c16;
    logic [63:0] ra, rb;
    logic [65:0] m;
    logic rs, rc;
    int n, k;
    for (int i = 0; i < 1000; i++) begin
      ra = pick(16); rb = pick(16); rs = 1'($urandom); rc = 1'($urandom);
      m = model(16, ra, rb, rs, rc);
      n = 0;
      while (!ir2 && n < 20) begin @(posedge clk); #1; n++; end
      vec++;
      if (ir2 !== 1'b1) begin err++; $display("FAIL r16_ready%0d got %b want 1", i, ir2); end
      a2 = ra[15:0]; b2 = rb[15:0]; s2 = rs; c2 = rc; iv2 = 1; or2 = 0;
      @(posedge clk); #1;
      iv2 = 0; a2 = 16'($urandom); b2 = 16'($urandom); s2 = 1'($urandom); c2 = 1'($urandom);
      n = 0;
      while (!ov2 && n < 20) begin @(posedge clk); #1; n++; end
      vec++;
      if (n != 1) begin err++; $display("FAIL r16_latency%0d got %0d want 1", i, n); end
      vec++;
      if ({o2, co2, vf2, z2, n2} !== {m[15:0], m[64], m[65], m[15:0] == 16'h0, m[15]}) begin
        err++; $display("FAIL r16_result%0d a=%h b=%h sub=%b cin=%b got out=%h c=%b v=%b z=%b n=%b want out=%h c=%b v=%b", i, ra[15:0], rb[15:0], rs, rc, o2, co2, vf2, z2, n2, m[15:0], m[64], m[65]);
      end
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        @(posedge clk); #1;
        vec++;
        if ({ov2, ir2, o2} !== {2'b10, m[15:0]}) begin err++; $display("FAIL r16_hold%0d got v=%b r=%b out=%h want v=1 r=0 out=%h", i, ov2, ir2, o2, m[15:0]); end
      end
      or2 = 1;
      @(posedge clk); #1;
      or2 = 1'($urandom);
      vec++;
      if ({ov2, ir2} !== 2'b01) begin err++; $display("FAIL r16_take%0d got v=%b r=%b want v=0 r=1", i, ov2, ir2); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_run;
    test_random_w32_c8;
    test_random_w16_c16;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
